// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: ROM port plus the decoder-facing instruction/redirect signals.
interface instr_fetch_if #(
   parameter int ADDR_W = 8
) ();
   logic [ADDR_W-1:0] rom_addr;
   logic [48:0]       rom_data;
   logic              stall;
   logic              branch;
   logic [ADDR_W-1:0] branch_target;
   logic [48:0]       instruction;
   logic              instr_valid;
   logic [ADDR_W-1:0] instr_pc;
   logic              halted;

   modport master (
      output rom_addr,
      input  rom_data,
      input  stall,
      input  branch,
      input  branch_target,
      output instruction,
      output instr_valid,
      output instr_pc,
      output halted
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      output stall,
      output branch,
      output branch_target,
      input  instruction,
      input  instr_valid,
      input  instr_pc,
      input  halted
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: pc/ROM sequencing, 1-entry skid on stall, branch redirect with squash.
// Define FETCH_HALT_EN to stop fetching on a word whose opcode bits [48:44] are zero.
module instr_fetch #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic          clk,
   input  logic          reset,
   instr_fetch_if.master bus
);

`ifdef FETCH_HALT_EN
   typedef enum logic [1:0] {ST_START = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_e;
`else
   typedef enum logic [1:0] {ST_START = 2'd0, ST_RUN = 2'd1} state_e;
`endif

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              rd_valid_q, rd_valid_d;
   logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
   logic [48:0]       skid_q, skid_d;
   logic              skid_valid_q, skid_valid_d;
   logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
   logic [48:0]       instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              cand_valid_s;
   logic [48:0]       cand_word_s;
   logic [ADDR_W-1:0] cand_pc_s;
`ifdef FETCH_HALT_EN
   logic              halted_q, halted_d;
`endif

   // rd_valid marks the ROM word now on rom_data as a live fetch; a stalled
   // cycle does not count as a fetch because pc is held and re-reads the same address.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      rd_valid_d    = 1'b0;
      rd_pc_d       = pc_q;
      skid_d        = skid_q;
      skid_valid_d  = skid_valid_q;
      skid_pc_d     = skid_pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      instr_pc_d    = instr_pc_q;
`ifdef FETCH_HALT_EN
      halted_d      = halted_q;
`endif
      cand_valid_s  = skid_valid_q | rd_valid_q;
      if (skid_valid_q) begin
         cand_word_s = skid_q;
         cand_pc_s   = skid_pc_q;
      end else begin
         cand_word_s = bus.rom_data;
         cand_pc_s   = rd_pc_q;
      end

      case (state_q)
         ST_START, ST_RUN: begin
            state_d = ST_RUN;
            if (bus.branch) begin
               pc_d          = bus.branch_target;
               skid_valid_d  = 1'b0;
               instr_valid_d = 1'b0;
            end else if (bus.stall) begin
               if (rd_valid_q) begin
                  skid_d       = bus.rom_data;
                  skid_pc_d    = rd_pc_q;
                  skid_valid_d = 1'b1;
               end else begin
                  skid_valid_d = skid_valid_q;
               end
            end else begin
`ifdef FETCH_HALT_EN
               if (cand_valid_s && (cand_word_s[48:44] == 5'h00)) begin
                  state_d       = ST_HALT;
                  halted_d      = 1'b1;
                  instr_valid_d = 1'b0;
                  skid_valid_d  = 1'b0;
               end else begin
`endif
                  pc_d          = pc_q + PC_ONE;
                  rd_valid_d    = 1'b1;
                  rd_pc_d       = pc_q;
                  skid_valid_d  = 1'b0;
                  instr_valid_d = cand_valid_s;
                  if (cand_valid_s) begin
                     instr_d    = cand_word_s;
                     instr_pc_d = cand_pc_s;
                  end else begin
                     instr_d    = instr_q;
                     instr_pc_d = instr_pc_q;
                  end
`ifdef FETCH_HALT_EN
               end
`endif
            end
         end
`ifdef FETCH_HALT_EN
         ST_HALT: begin
            state_d = ST_HALT;
         end
`endif
         default: begin
            state_d       = ST_START;
            pc_d          = RESET_PC;
            skid_valid_d  = 1'b0;
            instr_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_START;
         pc_q          <= RESET_PC;
         rd_valid_q    <= 1'b0;
         rd_pc_q       <= {ADDR_W{1'b0}};
         skid_q        <= 49'h0;
         skid_valid_q  <= 1'b0;
         skid_pc_q     <= {ADDR_W{1'b0}};
         instr_q       <= 49'h0;
         instr_valid_q <= 1'b0;
         instr_pc_q    <= {ADDR_W{1'b0}};
`ifdef FETCH_HALT_EN
         halted_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         rd_valid_q    <= rd_valid_d;
         rd_pc_q       <= rd_pc_d;
         skid_q        <= skid_d;
         skid_valid_q  <= skid_valid_d;
         skid_pc_q     <= skid_pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         instr_pc_q    <= instr_pc_d;
`ifdef FETCH_HALT_EN
         halted_q      <= halted_d;
`endif
      end
   end

   assign bus.rom_addr    = pc_q;
   assign bus.instruction = instr_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr_pc    = instr_pc_q;
`ifdef FETCH_HALT_EN
   assign bus.halted      = halted_q;
`else
   assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised scoreboard bench for instr_fetch: expected address/word streams pushed on
// reset/branch, a negedge monitor pops them on every consumed instruction.
`timescale 1ns/1ps
module tb_instr_fetch;
   localparam int         ADDR_W   = 8;
   localparam logic [7:0] RESET_PC = 8'h00;

   typedef struct packed {
      logic        flush;
      logic [7:0]  addr;
      logic [48:0] word;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [48:0] rom [0:255];
   exp_t        sb_q [$];
   int          checks = 0;
   int          errors = 0;

   logic        p1_ok = 1'b0, p2_ok = 1'b0, p1_bad = 1'b1, p2_bad = 1'b1, p1_frz = 1'b0;
   logic        prev_rst = 1'b1, model_halted = 1'b0;
   logic [7:0]  halt_addr = 8'h00;
   logic [48:0] prev_instr = 49'h0;
   logic        prev_valid = 1'b0;
   logic [7:0]  prev_ipc = 8'h00, prev_addr = 8'h00;

   instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

   instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: word appears one cycle after its address.
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

`ifdef FETCH_HALT_EN
   function automatic logic is_halt(input logic [48:0] w);
      logic [4:0] op;
      op = w[48:44];
      return op == 5'd0;
   endfunction
`endif

   task automatic push_stream(input logic [7:0] start);
      exp_t       e;
      logic [7:0] a;
      e.flush = 1'b1; e.addr = 8'h00; e.word = 49'h0;
      sb_q.push_back(e);
      a = start;
      for (int i = 0; i < 256; i++) begin
         e.flush = 1'b0; e.addr = a; e.word = rom[a];
         sb_q.push_back(e);
         a = a + 8'd1;
      end
   endtask

   task automatic flush_to_marker();
      while (sb_q.size() > 0 && !sb_q[0].flush) void'(sb_q.pop_front());
      if (sb_q.size() > 0) void'(sb_q.pop_front());
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pc(input logic [7:0] a, input int max, output logic found);
      found = 1'b0;
      for (int i = 0; i < max && found == 1'b0; i++) begin
         if (bus.instr_valid && bus.instr_pc == a) found = 1'b1;
         else step();
      end
   endtask

   // Monitor: timing rules and in-order stream comparison, sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (prev_rst) flush_to_marker();
            model_halted = 1'b0;
            p2_ok = p1_ok; p1_ok = 1'b0;
            p2_bad = p1_bad; p1_bad = 1'b1;
            p1_frz = 1'b0;
         end else begin
            if (model_halted) begin
               check("halt_hold", bus.halted, 1'b1);
               check("halt_novalid", bus.instr_valid, 1'b0);
               check("halt_pc_frozen", bus.rom_addr, halt_addr);
            end
`ifdef FETCH_HALT_EN
            else if (bus.halted) begin
               check("halt_expected", (sb_q.size() > 0 && !sb_q[0].flush && is_halt(sb_q[0].word)), 1'b1);
               check("halt_valid", bus.instr_valid, 1'b0);
               model_halted = 1'b1;
               halt_addr = bus.rom_addr;
            end
`endif
            else begin
               if (p1_ok && p2_ok) check("gap", bus.instr_valid, 1'b1);
               if (p1_bad || p2_bad) check("squash", bus.instr_valid, 1'b0);
               if (p1_frz) begin
                  check("frz_instr", bus.instruction, prev_instr);
                  check("frz_valid", bus.instr_valid, prev_valid);
                  check("frz_ipc", bus.instr_pc, prev_ipc);
                  check("frz_pc", bus.rom_addr, prev_addr);
               end
               if (bus.instr_valid && (!bus.stall || bus.branch)) begin
                  if (sb_q.size() == 0 || sb_q[0].flush) begin
                     checks++; errors++;
                     $display("FAIL sb_underflow actual_pc=%0h required=stream_entry", bus.instr_pc);
                  end else begin
                     e = sb_q.pop_front();
                     check("sb_pc", bus.instr_pc, e.addr);
                     check("sb_word", bus.instruction, e.word);
`ifdef FETCH_HALT_EN
                     check("halt_issued", is_halt(bus.instruction), 1'b0);
`endif
                  end
               end
               if (bus.branch) flush_to_marker();
            end
`ifndef FETCH_HALT_EN
            check("halted_tied", bus.halted, 1'b0);
`endif
            p2_ok  = p1_ok;  p1_ok  = !bus.stall && !bus.branch;
            p2_bad = p1_bad; p1_bad = bus.branch && !model_halted;
            p1_frz = bus.stall && !bus.branch && !model_halted;
         end
         prev_instr = bus.instruction;
         prev_valid = bus.instr_valid;
         prev_ipc   = bus.instr_pc;
         prev_addr  = bus.rom_addr;
         prev_rst   = reset;
      end
   end

   // Stimulus: directed scenarios followed by a randomised stall/branch phase.
   initial begin
      logic [63:0] w64;
      logic        found;
      logic [7:0]  saved;
      logic [7:0]  tgt;
      for (int i = 0; i < 256; i++) begin
         w64 = {$urandom, $urandom};
         rom[i] = w64[48:0];
         rom[i][44] = 1'b1;
      end
      rom[0] = 49'h1001ABCDEF12;
      rom[1] = 49'h141D1234DADA;
      rom[2] = 49'h27A000000010;
      rom[3] = 49'h391F0000000A;
      rom[5] = 49'h0000000000000;
      bus.stall = 1'b0; bus.branch = 1'b0; bus.branch_target = 8'h00;

      #2;
      push_stream(RESET_PC);
      reset = 1'b0;
      #1;
      check("rst_instr", bus.instruction, 49'h0);
      check("rst_valid", bus.instr_valid, 1'b0);
      check("rst_ipc", bus.instr_pc, 8'h00);
      check("rst_halted", bus.halted, 1'b0);
      check("rst_pc", bus.rom_addr, RESET_PC);
      step(); step();
      reset = 1'b1;
      check("start_valid", bus.instr_valid, 1'b0);
      check("start_pc", bus.rom_addr, RESET_PC);
      step();
      check("c1_valid", bus.instr_valid, 1'b0);
      step();
      check("w0_valid", bus.instr_valid, 1'b1);
      check("w0_pc", bus.instr_pc, 8'h00);
      check("w0_word", bus.instruction, 49'h1001ABCDEF12);
      step();
      check("w1_pc", bus.instr_pc, 8'h01);
      check("w1_word", bus.instruction, 49'h141D1234DADA);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 2) bus.stall = 1'b0;
         check("stall_word", bus.instruction, 49'h141D1234DADA);
         check("stall_pc", bus.instr_pc, 8'h01);
      end
      step();
      check("w2_pc", bus.instr_pc, 8'h02);
      check("w2_word", bus.instruction, 49'h27A000000010);
      push_stream(8'h10);
      bus.branch = 1'b1; bus.branch_target = 8'h10;
      step();
      bus.branch = 1'b0;
      check("br_bubble1", bus.instr_valid, 1'b0);
      step();
      check("br_bubble2", bus.instr_valid, 1'b0);
      step();
      check("br_tgt_valid", bus.instr_valid, 1'b1);
      check("br_tgt_pc", bus.instr_pc, 8'h10);
      check("br_tgt_word", bus.instruction, rom[8'h10]);

      push_stream(8'hF8);
      bus.branch = 1'b1; bus.branch_target = 8'hF8;
      step();
      bus.branch = 1'b0;
      wait_pc(8'hFF, 20, found);
      check("wait_ff", found, 1'b1);
      step();
      check("wrap_pc", bus.instr_pc, 8'h00);
      check("wrap_valid", bus.instr_valid, 1'b1);

      push_stream(8'h40);
      bus.stall = 1'b1; bus.branch = 1'b1; bus.branch_target = 8'h40;
      step();
      bus.stall = 1'b0; bus.branch = 1'b0;
      wait_pc(8'h40, 10, found);
      check("brstall_taken", found, 1'b1);
      check("brstall_word", bus.instruction, rom[8'h40]);

      push_stream(8'h00);
      bus.branch = 1'b1; bus.branch_target = 8'h00;
      step();
      bus.branch = 1'b0;
`ifdef FETCH_HALT_EN
      found = 1'b0;
      for (int i = 0; i < 30 && found == 1'b0; i++) begin
         if (bus.halted) found = 1'b1;
         else step();
      end
      check("halt_seen", found, 1'b1);
      check("halt_last_pc", bus.instr_pc, 8'h04);
      saved = bus.rom_addr;
      bus.branch = 1'b1; bus.branch_target = 8'h30;
      step();
      bus.branch = 1'b0;
      repeat (3) step();
      check("halt_br_ignored", bus.halted, 1'b1);
      check("halt_pc_same", bus.rom_addr, saved);
      rom[5] = 49'h1000000000005;
      #1;
      push_stream(RESET_PC);
      reset = 1'b0;
      #1;
      check("halt_rst_clear", bus.halted, 1'b0);
      step();
      reset = 1'b1;
`else
      wait_pc(8'h05, 12, found);
      check("op0_issued", found, 1'b1);
      check("op0_word", bus.instruction, 49'h0);
`endif

      wait_pc(8'h08, 40, found);
      check("wait_08", found, 1'b1);
      bus.stall = 1'b1;
      step(); step();
      #1;
      push_stream(RESET_PC);
      reset = 1'b0;
      #1;
      check("mrst_instr", bus.instruction, 49'h0);
      check("mrst_valid", bus.instr_valid, 1'b0);
      check("mrst_ipc", bus.instr_pc, 8'h00);
      check("mrst_halted", bus.halted, 1'b0);
      check("mrst_pc", bus.rom_addr, RESET_PC);
      step();
      bus.stall = 1'b0;
      step();
      reset = 1'b1;
      wait_pc(RESET_PC, 6, found);
      check("mrst_restart", found, 1'b1);
      check("mrst_word", bus.instruction, rom[RESET_PC]);

      for (int i = 0; i < 600; i++) begin
         bus.stall  = ($urandom_range(0, 3) == 0);
         bus.branch = ($urandom_range(0, 15) == 0);
         if (bus.branch) begin
            tgt = 8'($urandom_range(0, 255));
            bus.branch_target = tgt;
            push_stream(tgt);
         end
         step();
      end
      bus.stall = 1'b0; bus.branch = 1'b0;
      repeat (10) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the program-address width.
REQ-002 SHALL have parameter RESET_PC, default 0, the first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rom_addr  output  ADDR_W  program ROM address, equal to the registered pc.
REQ-006 SHALL have port rom_data  input  49  ROM word, valid one cycle after rom_addr (synchronous ROM).
REQ-007 SHALL have port stall  input  1  consumer (decoder) cannot accept a new instruction this cycle.
REQ-008 SHALL have port branch  input  1  redirect request from decoder.
REQ-009 SHALL have port branch_target  input  ADDR_W  redirect address, sampled when branch=1.
REQ-010 SHALL have port instruction  output  49  registered instruction word to the decoder.
REQ-011 SHALL have port instr_valid  output  1  instruction holds a real, unsquashed word.
REQ-012 SHALL have port instr_pc  output  ADDR_W  address the current instruction was fetched from.
REQ-013 SHALL have port halted  output  1  fetch stopped by halt word.

Function
REQ-014 SHALL run a 3-state FSM: START (one cycle after reset release, drives pc=RESET_PC, no valid data), RUN, HALT.
REQ-015 SHALL in RUN without stall increment pc by 1 each cycle, modulo 2^ADDR_W (all-ones wraps to 0, no flag).
REQ-016 SHALL present the word at address P on instruction with instr_valid=1 exactly 2 cycles after rom_addr=P, without stall.
REQ-017 SHALL, with stall=1, freeze pc, instruction, instr_valid and instr_pc, and capture the one in-flight ROM word in a 1-entry skid register.
REQ-018 SHALL, on stall release, issue the skid word first, then resume the ROM stream, with no word lost or duplicated.
REQ-019 SHALL, on branch=1 at edge t, load pc=branch_target at t+1, squash the skid word and all in-flight words, and drive instr_valid=0 until the target word appears at t+3.
REQ-020 SHALL give branch priority over stall when both are 1 in the same cycle.
REQ-021 SHALL treat branch while in START as a normal redirect, with RESET_PC overridden.
REQ-022 SHALL never assert instr_valid for a squashed word; instruction content while instr_valid=0 is don't-care but holds its previous value.

Reset
REQ-023 SHALL on reset low, asynchronously, set pc=RESET_PC, instruction=0, instr_valid=0, instr_pc=0, halted=0, skid empty, state=START.
REQ-024 SHALL abandon any in-flight, skid or stalled word on reset mid-operation, and restart from START on release.

Configuration
REQ-025 SHALL, with macro FETCH_HALT_EN defined, treat a word whose bits [48:44]=5'h00 as a halt: the word is not issued, instr_valid=0, halted=1, pc frozen, state=HALT until reset; branch is ignored in HALT.
REQ-026 SHALL, without FETCH_HALT_EN, issue opcode-0 words as normal instructions, tie halted to 0, and omit HALT state logic.

Verification
REQ-027 SHALL cover reset release, ROM[0..3]=49'h1001ABCDEF12,49'h141D1234DADA,49'h27A000000010,49'h391F0000000A, no stall -> those words with instr_valid=1 and instr_pc=0..3 on consecutive cycles, first word 2 cycles after pc=0.
REQ-028 SHALL cover stall=1 for 3 cycles while instr_pc=1 -> instruction holds 49'h141D1234DADA; after release instr_pc 2,3 follow with no gap or repeat.
REQ-029 SHALL cover branch=1, branch_target=8'h10 while instr_pc=2 -> two instr_valid=0 cycles, then instr_pc=8'h10 with ROM[0x10].
REQ-030 SHALL cover pc reaching 8'hFF with no stall -> next instr_pc=8'h00; also branch and stall asserted together -> the redirect is taken.
REQ-031 SHALL cover FETCH_HALT_EN with ROM[5]=49'h0000000000000 -> instr_pc 4 last valid, halted=1 and pc frozen; a later branch has no effect; reset clears halted=0.
REQ-032 SHALL cover reset pulled low mid-stall with the skid full -> all outputs reset immediately, and after release the fetch restarts at RESET_PC.
